tl_tx_vc_scheduler: RTL and testbench
=====================================

Name: tl_tx_vc_scheduler

Overview:
- Credit-gated weighted round-robin scheduler between the two TX virtual-channel FIFOs (VC0 low priority, VC1 high priority) and the data link layer.
- Tracks per-VC flow-control header and data credits from the link partner and grants a VC only if it has credits for the whole head TLP.
- Pops the granted FIFO and drives a registered single-entry output stage toward the DLL.

Parameters:
- DATA_WIDTH, 1024, TLP word width on FIFO and DLL sides.
- HIGH_WEIGHT, 3, grant phases per round preferring VC1.
- LOW_WEIGHT, 1, grant phases per round preferring VC0.
- HDR_CRED_W, 8, header-credit counter width.
- DATA_CRED_W, 12, data-credit counter width.
- INIT_HDR_CRED, 32, header credits per VC after reset; also the saturation ceiling.
- INIT_DATA_CRED, 512, data credits per VC after reset; also the saturation ceiling.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- vc0_data_i  in  DATA_WIDTH  head TLP of the VC0 FIFO.
- vc0_len_i  in  10  header length field of the VC0 head TLP, in DW; 0 means 1024 DW.
- vc0_valid_i  in  1  VC0 FIFO not empty.
- vc0_ready_o  out  1  pop strobe for the VC0 FIFO.
- vc1_data_i, vc1_len_i, vc1_valid_i, vc1_ready_o  same as VC0, for VC1.
- tlp_data_o  out  DATA_WIDTH  TLP to the DLL.
- tlp_valid_o  out  1  tlp_data_o is valid.
- tlp_ready_i  in  1  DLL accepts the TLP.
- fc_upd_valid_i  in  1  credit release from the DLL (UpdateFC).
- fc_upd_vc_i  in  1  VC being released.
- fc_upd_hdr_i  in  HDR_CRED_W  header credits released.
- fc_upd_data_i  in  DATA_CRED_W  data credits released.
- vc0_hdr_cred_o, vc1_hdr_cred_o  out  HDR_CRED_W  current header credits (status).
- vc0_data_cred_o, vc1_data_cred_o  out  DATA_CRED_W  current data credits (status).

Behaviour:
- Reset values:
  - tlp_valid_o=0, tlp_data_o=0, vcX_ready_o=0.
  - phase=0.
  - Credit counters = INIT_HDR_CRED / INIT_DATA_CRED.
- Data-credit need of a TLP: ceil(len/4), one credit = 4 DW. len=0 counts as 1024 DW, so need=256.
- Eligibility: VCx is eligible when vcX_valid_i=1, hdr_cred>=1 and data_cred>=need(vcX_len_i).
  - The check uses this cycle's register values only; a same-cycle fc update does not count.
- Output stage:
  - slot_free = !tlp_valid_o || tlp_ready_i.
  - A grant happens only when slot_free=1 and at least one VC is eligible.
- Phase counter runs 0..HIGH_WEIGHT+LOW_WEIGHT-1 and wraps to 0.
  - Phases below HIGH_WEIGHT prefer VC1; the remaining phases prefer VC0.
  - If the preferred VC is ineligible and the other is eligible, the other is granted (work-conserving).
  - The phase advances by 1 on every grant, whichever VC wins. No grant means no advance.
- On a grant (same cycle):
  - vcX_ready_o=1, combinational, for exactly that cycle.
  - The granted VC's hdr_cred decrements by 1 and its data_cred decrements by need.
  - Next edge: tlp_data_o <= vcX_data_i, tlp_valid_o <= 1.
- Latency: 1 cycle from grant to tlp_valid_o. Back-to-back grants every cycle while tlp_ready_i=1.
- Hold: tlp_valid_o=1 with tlp_ready_i=0 keeps tlp_data_o stable and blocks further grants.
- Credits:
  - Accepted with no grant → tlp_valid_o <= 0.
  - fc update adds the released credits to the addressed VC and saturates at the INIT ceiling.
  - Grant and update on the same VC in the same cycle: new = old - need + release, then saturate.
  - Counters never go below 0, guaranteed by the eligibility rule.
- Starvation: a VC with insufficient credits stays blocked and does not hold back the other VC.
- Reset mid-operation: the output register is cleared, any held TLP is dropped, and the credit counters are re-initialised.

Decomposition:
- Package tl_tx_pkg:
  - Typedef vc_e (VC0, VC1).
  - Credit-width localparams.
  - Function data_cred_need(len) implementing the ceil rule and the 0→1024 DW rule.
  - Mapping constant TC>=5 → VC1.
- Sub-module tl_fc_credit_cnt, instantiated twice (one per VC):
  - Holds the header and data counters.
  - Handles consume/release with saturation.
  - Outputs sufficient = hdr>=1 && data>=need.

Test Plan:
- Both VCs continuously valid, len=1, credits plentiful, tlp_ready_i=1 → grant order VC1,VC1,VC1,VC0 repeating; 8 TLPs in 8 consecutive cycles.
- Only VC0 valid, 5 TLPs → VC0 granted every cycle while the phase cycles 0..3; 5 pops.
- VC1 data_cred=10, head len=64 (need 16), VC0 valid → VC1 never granted and VC0 proceeds. Then fc update VC1 +6 data → VC1 granted on the next preferred or free grant, and VC1 data_cred returns to 0.
- tlp_ready_i=0 for 5 cycles with tlp_valid_o=1 → tlp_data_o constant, vcX_ready_o=0 and credits unchanged. Release → the next grant happens in the same cycle.
- len=0 on VC0 with data_cred=255 → not eligible. Update +1 → granted, data_cred=0.
- Same-cycle grant on VC1 (need 2) and fc update VC1 +5 with data_cred=510, ceiling 512 → data_cred=512 (saturated). Then assert reset mid-stream → tlp_valid_o=0 immediately and credits = 32/512.

Source files
------------

// File: rtl/tl_tx_pkg.sv
// Shared types and helpers for the TX virtual-channel scheduler.
// Credit arithmetic follows the one-credit-per-4-DW data unit.
package tl_tx_pkg;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_e;

    localparam int HDR_CRED_W_DEF  = 8;
    localparam int DATA_CRED_W_DEF = 12;
    localparam int LEN_W           = 10;
    localparam int NEED_W          = 9;
    localparam int DW_PER_CRED     = 4;

    // Traffic classes at or above this value ride on VC1.
    localparam logic [2:0] TC_VC1_MIN = 3'd5;

    function automatic vc_e tc_to_vc(input logic [2:0] tc);
        return (tc >= TC_VC1_MIN) ? VC1 : VC0;
    endfunction

    // A zero length field encodes the maximum 1024 DW payload.
    function automatic logic [NEED_W-1:0] data_cred_need(
        input logic [LEN_W-1:0] len
    );
        logic [LEN_W:0] rounded;
        rounded = {1'b0, len} + (LEN_W + 1)'(DW_PER_CRED - 1);
        if (len == '0) begin
            return NEED_W'(1024 / DW_PER_CRED);
        end
        return rounded[LEN_W:2];
    endfunction

endpackage

// File: rtl/tl_tx_vc_scheduler_credit.sv
// Per-VC header/data flow-control credit counter.
// Consume and release may coincide; the result saturates at the initial grant.
module tl_fc_credit_cnt
    import tl_tx_pkg::*;
#(
    parameter int HDR_W     = 8,
    parameter int DATA_W    = 12,
    parameter int INIT_HDR  = 32,
    parameter int INIT_DATA = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NEED_W-1:0] need_i,
    input  logic              consume_i,
    input  logic              rel_valid_i,
    input  logic [HDR_W-1:0]  rel_hdr_i,
    input  logic [DATA_W-1:0] rel_data_i,
    output logic [HDR_W-1:0]  hdr_cred_o,
    output logic [DATA_W-1:0] data_cred_o,
    output logic              sufficient_o
);

    logic [HDR_W-1:0]  hdr_q;
    logic [HDR_W-1:0]  hdr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [HDR_W:0]    hdr_sum;
    logic [DATA_W:0]   data_sum;

    always_comb begin
        hdr_sum  = {1'b0, hdr_q};
        data_sum = {1'b0, data_q};
        // Consume is only asserted when sufficient, so no underflow here.
        if (consume_i) begin
            hdr_sum  = hdr_sum - (HDR_W + 1)'(1);
            data_sum = data_sum - (DATA_W + 1)'(need_i);
        end
        if (rel_valid_i) begin
            hdr_sum  = hdr_sum + {1'b0, rel_hdr_i};
            data_sum = data_sum + {1'b0, rel_data_i};
        end
        if (hdr_sum > (HDR_W + 1)'(INIT_HDR)) begin
            hdr_d = HDR_W'(INIT_HDR);
        end else begin
            hdr_d = hdr_sum[HDR_W-1:0];
        end
        if (data_sum > (DATA_W + 1)'(INIT_DATA)) begin
            data_d = DATA_W'(INIT_DATA);
        end else begin
            data_d = data_sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_q  <= HDR_W'(INIT_HDR);
            data_q <= DATA_W'(INIT_DATA);
        end else begin
            hdr_q  <= hdr_d;
            data_q <= data_d;
        end
    end

    assign hdr_cred_o   = hdr_q;
    assign data_cred_o  = data_q;
    assign sufficient_o = (hdr_q != '0) && (data_q >= DATA_W'(need_i));

endmodule

// File: rtl/tl_tx_vc_scheduler.sv
// Credit-gated weighted round-robin between the VC0/VC1 TX FIFOs,
// feeding a single registered output slot toward the data link layer.
module tl_tx_vc_scheduler
    import tl_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 1024,
    parameter int HIGH_WEIGHT    = 3,
    parameter int LOW_WEIGHT     = 1,
    parameter int HDR_CRED_W     = HDR_CRED_W_DEF,
    parameter int DATA_CRED_W    = DATA_CRED_W_DEF,
    parameter int INIT_HDR_CRED  = 32,
    parameter int INIT_DATA_CRED = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  vc0_data_i,
    input  logic [LEN_W-1:0]       vc0_len_i,
    input  logic                   vc0_valid_i,
    output logic                   vc0_ready_o,
    input  logic [DATA_WIDTH-1:0]  vc1_data_i,
    input  logic [LEN_W-1:0]       vc1_len_i,
    input  logic                   vc1_valid_i,
    output logic                   vc1_ready_o,
    output logic [DATA_WIDTH-1:0]  tlp_data_o,
    output logic                   tlp_valid_o,
    input  logic                   tlp_ready_i,
    input  logic                   fc_upd_valid_i,
    input  logic                   fc_upd_vc_i,
    input  logic [HDR_CRED_W-1:0]  fc_upd_hdr_i,
    input  logic [DATA_CRED_W-1:0] fc_upd_data_i,
    output logic [HDR_CRED_W-1:0]  vc0_hdr_cred_o,
    output logic [HDR_CRED_W-1:0]  vc1_hdr_cred_o,
    output logic [DATA_CRED_W-1:0] vc0_data_cred_o,
    output logic [DATA_CRED_W-1:0] vc1_data_cred_o
);

    localparam int PH_N = HIGH_WEIGHT + LOW_WEIGHT;
    localparam int PH_W = (PH_N > 1) ? $clog2(PH_N) : 1;

    logic [PH_W-1:0]       phase_q;
    logic [PH_W-1:0]       phase_d;
    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    logic [NEED_W-1:0] need0;
    logic [NEED_W-1:0] need1;
    logic              suff0;
    logic              suff1;
    logic              elig0;
    logic              elig1;
    logic              slot_free;
    logic              pref_vc1;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    vc_e               gnt_vc;
    vc_e               upd_vc;
    logic              rel0;
    logic              rel1;

    always_comb begin
        need0     = data_cred_need(vc0_len_i);
        need1     = data_cred_need(vc1_len_i);
        elig0     = vc0_valid_i && suff0;
        elig1     = vc1_valid_i && suff1;
        slot_free = !valid_q || tlp_ready_i;
        pref_vc1  = phase_q < PH_W'(HIGH_WEIGHT);
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        // Preferred VC wins; otherwise fall through to any eligible VC.
        if (!reset && slot_free) begin
            if (elig1 && (pref_vc1 || !elig0)) begin
                gnt1 = 1'b1;
            end else if (elig0) begin
                gnt0 = 1'b1;
            end
        end
        any_gnt = gnt0 || gnt1;
        gnt_vc  = gnt1 ? VC1 : VC0;
        upd_vc  = vc_e'(fc_upd_vc_i);
        rel0    = fc_upd_valid_i && (upd_vc == VC0);
        rel1    = fc_upd_valid_i && (upd_vc == VC1);
    end

    always_comb begin
        phase_d = phase_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (any_gnt) begin
            if (phase_q == PH_W'(PH_N - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
            valid_d = 1'b1;
            data_d  = (gnt_vc == VC1) ? vc1_data_i : vc0_data_i;
        end else if (tlp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    tl_fc_credit_cnt #(
        .HDR_W     (HDR_CRED_W),
        .DATA_W    (DATA_CRED_W),
        .INIT_HDR  (INIT_HDR_CRED),
        .INIT_DATA (INIT_DATA_CRED)
    ) u_cred_vc0 (
        .clk          (clk),
        .reset        (reset),
        .need_i       (need0),
        .consume_i    (gnt0),
        .rel_valid_i  (rel0),
        .rel_hdr_i    (fc_upd_hdr_i),
        .rel_data_i   (fc_upd_data_i),
        .hdr_cred_o   (vc0_hdr_cred_o),
        .data_cred_o  (vc0_data_cred_o),
        .sufficient_o (suff0)
    );

    tl_fc_credit_cnt #(
        .HDR_W     (HDR_CRED_W),
        .DATA_W    (DATA_CRED_W),
        .INIT_HDR  (INIT_HDR_CRED),
        .INIT_DATA (INIT_DATA_CRED)
    ) u_cred_vc1 (
        .clk          (clk),
        .reset        (reset),
        .need_i       (need1),
        .consume_i    (gnt1),
        .rel_valid_i  (rel1),
        .rel_hdr_i    (fc_upd_hdr_i),
        .rel_data_i   (fc_upd_data_i),
        .hdr_cred_o   (vc1_hdr_cred_o),
        .data_cred_o  (vc1_data_cred_o),
        .sufficient_o (suff1)
    );

    assign vc0_ready_o = gnt0;
    assign vc1_ready_o = gnt1;
    assign tlp_valid_o = valid_q;
    assign tlp_data_o  = data_q;

endmodule

// File: tb/tb_tl_tx_vc_scheduler.sv
// Directed bench for tl_tx_vc_scheduler: arbitration order, credit gating,
// output hold, len=0 handling, saturation and mid-stream reset.
module tb_tl_tx_vc_scheduler;

    localparam int DW = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] vc0_data;
    logic [9:0]    vc0_len;
    logic          vc0_valid;
    logic          vc0_ready;
    logic [DW-1:0] vc1_data;
    logic [9:0]    vc1_len;
    logic          vc1_valid;
    logic          vc1_ready;
    logic [DW-1:0] tlp_data;
    logic          tlp_valid;
    logic          tlp_ready;
    logic          fc_valid;
    logic          fc_vc;
    logic [7:0]    fc_hdr;
    logic [11:0]   fc_dat;
    logic [7:0]    vc0_hc;
    logic [7:0]    vc1_hc;
    logic [11:0]   vc0_dc;
    logic [11:0]   vc1_dc;

    int total = 0;
    int bad   = 0;

    tl_tx_vc_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .vc0_data_i      (vc0_data),
        .vc0_len_i       (vc0_len),
        .vc0_valid_i     (vc0_valid),
        .vc0_ready_o     (vc0_ready),
        .vc1_data_i      (vc1_data),
        .vc1_len_i       (vc1_len),
        .vc1_valid_i     (vc1_valid),
        .vc1_ready_o     (vc1_ready),
        .tlp_data_o      (tlp_data),
        .tlp_valid_o     (tlp_valid),
        .tlp_ready_i     (tlp_ready),
        .fc_upd_valid_i  (fc_valid),
        .fc_upd_vc_i     (fc_vc),
        .fc_upd_hdr_i    (fc_hdr),
        .fc_upd_data_i   (fc_dat),
        .vc0_hdr_cred_o  (vc0_hc),
        .vc1_hdr_cred_o  (vc1_hc),
        .vc0_data_cred_o (vc0_dc),
        .vc1_data_cred_o (vc1_dc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] wide(input logic [63:0] v);
        logic [DW-1:0] w;
        w = '0;
        w[63:0] = v;
        return w;
    endfunction

    task automatic chk_cred(input string tag, input logic [7:0] h0,
                            input logic [11:0] d0, input logic [7:0] h1,
                            input logic [11:0] d1);
        chk({tag, "_h0"}, vc0_hc, h0);
        chk({tag, "_d0"}, vc0_dc, d0);
        chk({tag, "_h1"}, vc1_hc, h1);
        chk({tag, "_d1"}, vc1_dc, d1);
    endtask

    logic        exp1;
    logic [63:0] prev;

    initial begin
        reset     = 1'b1;
        vc0_data  = '0;
        vc1_data  = '0;
        vc0_len   = '0;
        vc1_len   = '0;
        vc0_valid = 1'b0;
        vc1_valid = 1'b0;
        tlp_ready = 1'b0;
        fc_valid  = 1'b0;
        fc_vc     = 1'b0;
        fc_hdr    = '0;
        fc_dat    = '0;
        prev      = '0;
        #2;
        chk("rst_valid", tlp_valid, 0);
        chk("rst_data", tlp_data[63:0], 0);
        chk("rst_rdy0", vc0_ready, 0);
        chk("rst_rdy1", vc1_ready, 0);
        chk_cred("rst", 32, 512, 32, 512);
        tick();
        tick();
        reset = 1'b0;

        // Weighted order VC1,VC1,VC1,VC0 with both VCs backlogged.
        vc0_data  = wide(64'hA0);
        vc1_data  = wide(64'hB1);
        vc0_len   = 10'd1;
        vc1_len   = 10'd1;
        vc0_valid = 1'b1;
        vc1_valid = 1'b1;
        tlp_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp1 = (i % 4) != 3;
            chk("a_rdy1", vc1_ready, exp1);
            chk("a_rdy0", vc0_ready, !exp1);
            if (i > 0) begin
                chk("a_valid", tlp_valid, 1);
                chk("a_data", tlp_data[63:0], prev);
            end
            prev = exp1 ? 64'hB1 : 64'hA0;
            tick();
            #1;
        end
        vc0_valid = 1'b0;
        vc1_valid = 1'b0;
        #1;
        chk("a_last_valid", tlp_valid, 1);
        chk("a_last_data", tlp_data[63:0], 64'hA0);
        chk("a_idle_rdy0", vc0_ready, 0);
        chk("a_idle_rdy1", vc1_ready, 0);
        chk_cred("a", 30, 510, 26, 506);
        tick();
        chk("a_drain", tlp_valid, 0);

        // Only VC0 offered: it wins every phase.
        vc0_len   = 10'd4;
        vc0_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("b_rdy0", vc0_ready, 1);
            chk("b_rdy1", vc1_ready, 0);
            tick();
            #1;
        end
        vc0_valid = 1'b0;
        chk_cred("b", 25, 505, 26, 506);
        tick();

        // Drain VC1 data credits down to 10 (len 0 then len 960).
        vc1_data  = wide(64'hB2);
        vc1_len   = 10'd0;
        vc1_valid = 1'b1;
        #1;
        chk("c_drain0", vc1_ready, 1);
        tick();
        vc1_len = 10'd960;
        #1;
        chk("c_drain1", vc1_ready, 1);
        tick();
        vc1_valid = 1'b0;
        chk_cred("c_pre", 25, 505, 24, 10);
        tick();

        // VC1 starved (need 16, have 10); VC0 keeps flowing.
        vc1_data  = wide(64'hB1);
        vc1_len   = 10'd64;
        vc1_valid = 1'b1;
        vc0_data  = wide(64'hA0);
        vc0_len   = 10'd4;
        vc0_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("c_starve1", vc1_ready, 0);
            chk("c_flow0", vc0_ready, 1);
            tick();
            #1;
        end
        fc_valid = 1'b1;
        fc_vc    = 1'b1;
        fc_hdr   = 8'd0;
        fc_dat   = 12'd6;
        #1;
        chk("c_upd_rdy1", vc1_ready, 0);
        chk("c_upd_rdy0", vc0_ready, 1);
        tick();
        fc_valid = 1'b0;
        #1;
        chk("c_d1_16", vc1_dc, 16);
        chk("c_gnt1", vc1_ready, 1);
        chk("c_nogn0", vc0_ready, 0);
        tick();
        chk("c_out1", tlp_data[63:0], 64'hB1);
        vc0_valid = 1'b0;
        vc1_valid = 1'b0;
        chk_cred("c", 20, 500, 23, 0);
        tick();

        // Back-pressure holds the slot and blocks grants.
        vc0_data  = wide(64'hC0);
        vc0_valid = 1'b1;
        #1;
        chk("d_gnt", vc0_ready, 1);
        tick();
        tlp_ready = 1'b0;
        vc0_data  = wide(64'hC1);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("d_hold_v", tlp_valid, 1);
            chk("d_hold_d", tlp_data[63:0], 64'hC0);
            chk("d_hold_r", vc0_ready, 0);
            chk("d_hold_c", vc0_dc, 499);
            tick();
            #1;
        end
        tlp_ready = 1'b1;
        #1;
        chk("d_release", vc0_ready, 1);
        tick();
        chk("d_next", tlp_data[63:0], 64'hC1);
        vc0_valid = 1'b0;
        chk_cred("d", 18, 498, 23, 0);
        tick();

        // len=0 needs 256 credits: 255 is not enough.
        vc0_data  = wide(64'hD0);
        vc0_len   = 10'd972;
        vc0_valid = 1'b1;
        #1;
        chk("e_g972", vc0_ready, 1);
        tick();
        vc0_len = 10'd0;
        #1;
        chk("e_d0_255", vc0_dc, 255);
        chk("e_block", vc0_ready, 0);
        tick();
        chk("e_block2", vc0_ready, 0);
        fc_valid = 1'b1;
        fc_vc    = 1'b0;
        fc_hdr   = 8'd0;
        fc_dat   = 12'd1;
        #1;
        chk("e_same_cyc", vc0_ready, 0);
        tick();
        fc_valid = 1'b0;
        #1;
        chk("e_d0_256", vc0_dc, 256);
        chk("e_gnt", vc0_ready, 1);
        tick();
        vc0_valid = 1'b0;
        chk_cred("e", 16, 0, 23, 0);
        tick();

        // Simultaneous consume and release on VC1, then saturate.
        fc_valid = 1'b1;
        fc_vc    = 1'b1;
        fc_hdr   = 8'd0;
        fc_dat   = 12'd510;
        tick();
        fc_valid = 1'b0;
        #1;
        chk("f_d1_510", vc1_dc, 510);
        vc1_data  = wide(64'hE1);
        vc1_len   = 10'd8;
        vc1_valid = 1'b1;
        fc_valid  = 1'b1;
        fc_hdr    = 8'd20;
        fc_dat    = 12'd5;
        #1;
        chk("f_gnt", vc1_ready, 1);
        tick();
        fc_valid = 1'b0;
        #1;
        chk("f_d1_sat", vc1_dc, 512);
        chk("f_h1_sat", vc1_hc, 32);
        chk("f_out_v", tlp_valid, 1);
        chk("f_out_d", tlp_data[63:0], 64'hE1);

        // Asynchronous reset mid-stream.
        reset = 1'b1;
        #1;
        chk("r_valid", tlp_valid, 0);
        chk("r_data", tlp_data[63:0], 0);
        chk("r_rdy1", vc1_ready, 0);
        chk_cred("r", 32, 512, 32, 512);
        vc1_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
